// File: rtl/xinput_pkg.sv
// xinput_pkg: XInput OUT report constants and parser state encoding.
package xinput_pkg;
  localparam logic [7:0] XOUT_TYPE_RUMBLE = 8'h00;
  localparam logic [7:0] XOUT_TYPE_LED = 8'h01;
  localparam int XOUT_LEN_RUMBLE = 8;
  localparam int XOUT_LEN_LED = 3;
  localparam logic [3:0] XOUT_LED_MAX = 4'hD;
  typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_CHECK} xout_state_e;
endpackage

// File: rtl/xout_pkt_framer.sv
// xout_pkt_framer: frames the EP01 byte stream into packets using an idle-gap timeout.
module xout_pkt_framer
  import xinput_pkg::*;
#(
  parameter int GAP_CYCLES = 256,
  parameter int MAX_BYTES = 8,
  localparam int CW = $clog2(MAX_BYTES + 1),
  localparam int GW = $clog2(GAP_CYCLES)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   frame_done,
  output logic [8*MAX_BYTES-1:0] frame_buf,
  output logic [CW-1:0]          frame_cnt,
  output logic                   frame_ovf,
  output logic                   busy
);
  xout_state_e state_q, state_d;
  logic [8*MAX_BYTES-1:0] buf_q, buf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic ovf_q, ovf_d, late_q, late_d;
  always_comb begin
    state_d = state_q;
    buf_d = buf_q;
    cnt_d = cnt_q;
    gap_d = gap_q;
    ovf_d = ovf_q;
    late_d = late_q;
    frame_done = 1'b0;
    case (state_q)
      ST_IDLE: if (in_valid) begin
        buf_d[7:0] = in_data;
        cnt_d = CW'(1);
        gap_d = '0;
        ovf_d = 1'b0;
        state_d = ST_RECV;
      end
      ST_RECV: if (in_valid) begin
        if (cnt_q < CW'(MAX_BYTES)) begin
          buf_d[{cnt_q, 3'b000} +: 8] = in_data;
          cnt_d = cnt_q + CW'(1);
        end else ovf_d = 1'b1;
        gap_d = '0;
      end else if (gap_q == GW'(GAP_CYCLES - 1)) begin
        frame_done = 1'b1;
        state_d = ST_CHECK;
      end else gap_d = gap_q + GW'(1);
      default: begin
        late_d = late_q | in_valid;
        state_d = ST_IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      buf_q <= '0;
      cnt_q <= '0;
      gap_q <= '0;
      ovf_q <= 1'b0;
      late_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      gap_q <= gap_d;
      ovf_q <= ovf_d;
      late_q <= late_d;
    end
  end
  assign frame_buf = buf_q;
  assign frame_cnt = cnt_q;
  assign frame_ovf = ovf_q;
  assign busy = state_q != ST_IDLE;
endmodule

// File: rtl/xinput_out_parser.sv
// xinput_out_parser: decodes XInput rumble/LED OUT reports and holds the last command.
// Optional XOUT_PKT_STATS_EN adds saturating good/error packet counters.
module xinput_out_parser
  import xinput_pkg::*;
#(
  parameter int GAP_CYCLES = 256,
  parameter int MAX_BYTES = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        usb_rstn,
  input  logic [7:0]  ep01_data,
  input  logic        ep01_valid,
  output logic [7:0]  rumble_left,
  output logic [7:0]  rumble_right,
  output logic        rumble_update,
  output logic [3:0]  led_cmd,
  output logic        led_update,
  output logic        pkt_error,
  output logic        busy
`ifdef XOUT_PKT_STATS_EN
  ,
  output logic [15:0] good_cnt,
  output logic [15:0] err_cnt
`endif
);
  localparam int CW = $clog2(MAX_BYTES + 1);
  logic clr_n, done, ovf, is_rumble, is_led, unused_bytes;
  logic [8*MAX_BYTES-1:0] fbuf;
  logic [CW-1:0] fcnt;
  logic [7:0] left_q, left_d, right_q, right_d;
  logic [3:0] led_q, led_d;
  logic rum_upd_q, rum_upd_d, led_upd_q, led_upd_d, err_q, err_d;
  assign clr_n = rstn & usb_rstn;
  xout_pkt_framer #(.GAP_CYCLES(GAP_CYCLES), .MAX_BYTES(MAX_BYTES)) u_framer (
    .clk(clk), .rstn(clr_n), .in_data(ep01_data), .in_valid(ep01_valid),
    .frame_done(done), .frame_buf(fbuf), .frame_cnt(fcnt), .frame_ovf(ovf), .busy(busy)
  );
  assign unused_bytes = ^fbuf[8*MAX_BYTES-1:40];
  always_comb begin
    is_rumble = fcnt == CW'(XOUT_LEN_RUMBLE) && fbuf[7:0] == XOUT_TYPE_RUMBLE
             && fbuf[15:8] == 8'(XOUT_LEN_RUMBLE) && !ovf;
    is_led = fcnt == CW'(XOUT_LEN_LED) && fbuf[7:0] == XOUT_TYPE_LED
          && fbuf[15:8] == 8'(XOUT_LEN_LED) && fbuf[23:16] <= {4'h0, XOUT_LED_MAX} && !ovf;
    rum_upd_d = done && is_rumble;
    led_upd_d = done && is_led;
    err_d = done && !is_rumble && !is_led;
    left_d = rum_upd_d ? fbuf[31:24] : left_q;
    right_d = rum_upd_d ? fbuf[39:32] : right_q;
    led_d = led_upd_d ? fbuf[19:16] : led_q;
  end
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      left_q <= '0;
      right_q <= '0;
      led_q <= '0;
      rum_upd_q <= 1'b0;
      led_upd_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      left_q <= left_d;
      right_q <= right_d;
      led_q <= led_d;
      rum_upd_q <= rum_upd_d;
      led_upd_q <= led_upd_d;
      err_q <= err_d;
    end
  end
  assign rumble_left = left_q;
  assign rumble_right = right_q;
  assign rumble_update = rum_upd_q;
  assign led_cmd = led_q;
  assign led_update = led_upd_q;
  assign pkt_error = err_q;
`ifdef XOUT_PKT_STATS_EN
  logic [15:0] good_q, good_d, bad_q, bad_d;
  always_comb begin
    good_d = (rum_upd_q || led_upd_q) && good_q != 16'hFFFF ? good_q + 16'd1 : good_q;
    bad_d = err_q && bad_q != 16'hFFFF ? bad_q + 16'd1 : bad_q;
  end
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      good_q <= '0;
      bad_q <= '0;
    end else begin
      good_q <= good_d;
      bad_q <= bad_d;
    end
  end
  assign good_cnt = good_q;
  assign err_cnt = bad_q;
`endif
endmodule

// File: tb/tb_xinput_out_parser.sv
// tb_xinput_out_parser: randomized and directed checks against a report-level model.
module tb_xinput_out_parser;
  localparam int GAP = 256;
  localparam int MAXB = 8;
  typedef logic [7:0] bq_t[$];
  logic clk = 1'b0, rstn = 1'b0, usb_rstn = 1'b1, ep01_valid = 1'b0;
  logic [7:0] ep01_data = 8'h00;
  logic [7:0] rumble_left, rumble_right;
  logic [3:0] led_cmd;
  logic rumble_update, led_update, pkt_error, busy;
  int checks = 0, errors = 0;
  logic [7:0] m_left = 0, m_right = 0;
  logic [3:0] m_led = 0;
  int m_good = 0, m_err = 0;
`ifdef XOUT_PKT_STATS_EN
  logic [15:0] good_cnt, err_cnt;
`endif

  always #5 clk = ~clk;

  xinput_out_parser #(.GAP_CYCLES(GAP), .MAX_BYTES(MAXB)) dut (
    .clk(clk), .rstn(rstn), .usb_rstn(usb_rstn), .ep01_data(ep01_data), .ep01_valid(ep01_valid),
    .rumble_left(rumble_left), .rumble_right(rumble_right), .rumble_update(rumble_update),
    .led_cmd(led_cmd), .led_update(led_update), .pkt_error(pkt_error), .busy(busy)
`ifdef XOUT_PKT_STATS_EN
    , .good_cnt(good_cnt), .err_cnt(err_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input bq_t q, input int sp);
    foreach (q[i]) begin
      ep01_valid = 1'b1;
      ep01_data = q[i];
      tick();
      ep01_valid = 1'b0;
      if (i != q.size() - 1) idle(sp - 1);
    end
  endtask

  function automatic int decode(input bq_t q);
    if (q.size() == 8 && q[0] == 8'h00 && q[1] == 8'h08) return 1;
    if (q.size() == 3 && q[0] == 8'h01 && q[1] == 8'h03 && q[2] <= 8'h0D) return 2;
    return 0;
  endfunction

  task automatic check_held(input string name);
    checks++;
    if ({rumble_left, rumble_right, led_cmd} !== {m_left, m_right, m_led}) begin
      errors++;
      $display("FAIL %s held: got L=%h R=%h led=%h expected L=%h R=%h led=%h",
               name, rumble_left, rumble_right, led_cmd, m_left, m_right, m_led);
    end
`ifdef XOUT_PKT_STATS_EN
    checks++;
    if (good_cnt !== 16'(m_good) || err_cnt !== 16'(m_err)) begin
      errors++;
      $display("FAIL %s stats: got good=%0d err=%0d expected good=%0d err=%0d",
               name, good_cnt, err_cnt, m_good, m_err);
    end
`endif
  endtask

  task automatic expect_pkt(input bq_t q, input string name);
    int kind;
    logic [2:0] exp_p;
    bit early;
    kind = decode(q);
    exp_p = kind == 1 ? 3'b100 : kind == 2 ? 3'b010 : 3'b001;
    early = 0;
    for (int k = 1; k <= GAP; k++) begin
      if ({rumble_update, led_update, pkt_error} !== 3'b000 || busy !== 1'b1) early = 1;
      tick();
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL %s early: pulse or busy drop before last+GAP+1, expected none", name);
    end
    checks++;
    if ({rumble_update, led_update, pkt_error} !== exp_p || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s pulse: got {ru,lu,err}=%b busy=%b expected %b busy=1",
               name, {rumble_update, led_update, pkt_error}, busy, exp_p);
    end
    if (kind == 1) begin
      m_left = q[3];
      m_right = q[4];
    end
    if (kind == 2) m_led = q[2][3:0];
    if (kind == 0) m_err++;
    else m_good++;
    tick();
    checks++;
    if ({rumble_update, led_update, pkt_error, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL %s after: got {ru,lu,err,busy}=%b expected 0000",
               name, {rumble_update, led_update, pkt_error, busy});
    end
    check_held(name);
  endtask

  task automatic run(input bq_t q, input int sp, input string name);
    send(q, sp);
    expect_pkt(q, name);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle(3);
    checks++;
    if ({rumble_left, rumble_right, led_cmd, rumble_update, led_update, pkt_error, busy} !== '0) begin
      errors++;
      $display("FAIL reset: got L=%h R=%h led=%h ru=%b lu=%b err=%b busy=%b expected all 0",
               rumble_left, rumble_right, led_cmd, rumble_update, led_update, pkt_error, busy);
    end
    rstn = 1'b1;
    idle(2);
    check_held("reset");
  endtask

  task automatic test_rumble();
    run('{8'h00, 8'h08, 8'h00, 8'h80, 8'h40, 8'h00, 8'h00, 8'h00}, 40, "rumble");
  endtask

  task automatic test_led();
    run('{8'h01, 8'h03, 8'h06}, 5, "led");
    run('{8'h01, 8'h03, 8'h0E}, 5, "led_bad_code");
  endtask

  task automatic test_overflow();
    run('{8'h00, 8'h08, 8'h00, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3, "overflow");
    run('{8'h00, 8'h08, 8'h00, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00}, 2, "rumble_after_ovf");
  endtask

  task automatic test_back_to_back();
    bq_t p1, p2;
    p1 = '{8'h00, 8'h08, 8'h00, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00};
    p2 = '{8'h00, 8'h08, 8'h00, 8'h56, 8'h78, 8'h00, 8'h00, 8'h00};
    send(p1, 1);
    idle(GAP - 2);
    send(p2, 1);
    expect_pkt({p1, p2}, "merged");
    run(p1, 1, "split_a");
    run(p2, 1, "split_b");
  endtask

  task automatic test_mid_clear();
    bit seen;
    send('{8'h00, 8'h08, 8'h00, 8'h99}, 2);
    usb_rstn = 1'b0;
    tick();
    usb_rstn = 1'b1;
    m_left = 0;
    m_right = 0;
    m_led = 0;
    m_good = 0;
    m_err = 0;
    seen = 0;
    for (int k = 0; k < GAP + 4; k++) begin
      if ({rumble_update, led_update, pkt_error, busy} !== 4'b0000) seen = 1;
      tick();
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL mid_clear: got pulse or busy after usb_rstn clear, expected none");
    end
    check_held("mid_clear");
    run('{8'h01, 8'h03, 8'h02}, 3, "led_after_clear");
  endtask

  task automatic test_random();
    bq_t q;
    int kind, len;
    for (int n = 0; n < 12; n++) begin
      q = {};
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        q = '{8'h00, 8'h08};
        repeat (6) q.push_back(8'($urandom));
      end else if (kind == 1) begin
        q = '{8'h01, 8'h03, 8'($urandom_range(0, 15))};
      end else begin
        len = $urandom_range(1, 10);
        repeat (len) q.push_back(8'($urandom_range(0, 3)));
      end
      run(q, $urandom_range(1, 40), $sformatf("random%0d", n));
    end
  endtask

  task automatic test_stats();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    m_left = 0;
    m_right = 0;
    m_led = 0;
    m_good = 0;
    m_err = 0;
    run('{8'h00, 8'h08, 8'h00, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00}, 1, "stats_g1");
    run('{8'h01, 8'h03, 8'h0D}, 1, "stats_g2");
    run('{8'h01, 8'h03}, 1, "stats_e1");
    run('{8'h01, 8'h03, 8'h00}, 1, "stats_g3");
    run('{8'h00, 8'h09, 8'h00, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00}, 1, "stats_e2");
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    m_left = 0;
    m_right = 0;
    m_led = 0;
    m_good = 0;
    m_err = 0;
    check_held("rstn_clear");
  endtask

  initial begin
    test_reset();
    test_rumble();
    test_led();
    test_overflow();
    test_back_to_back();
    test_mid_clear();
    test_random();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/xinput_out_parser.md
Name: xinput_out_parser

Overview:
- Receives the EP01 interrupt OUT byte stream (ep01_data/ep01_valid) from usbfs_core_top.
- Frames each byte stream into packets using an idle-gap timeout.
- Decodes the XInput host-to-device reports (rumble, LED ring) and holds the last valid command in registers for the controller-side logic.
- Sits beside the EP81 IN report path in the gamepad top; it is the OUT-direction counterpart of that path.

Parameters:
- GAP_CYCLES, 256: number of idle clk cycles after the last byte that marks end-of-packet. Must be in the range 48..4095; 60 MHz clk is assumed.
- MAX_BYTES, 8: capture buffer depth in bytes. Longer packets are discarded.

Ports:
- clk  in  1  60 MHz system clock, the same clock as usbfs_core_top
- rstn  in  1  synchronous active-low reset
- usb_rstn  in  1  link-up from usbfs_core_top; 0 acts as a synchronous clear, identical to reset
- ep01_data  in  8  OUT payload byte
- ep01_valid  in  1  byte strobe, one cycle per byte, no backpressure
- rumble_left  out  8  large-motor strength, 0x00–0xFF
- rumble_right  out  8  small-motor strength
- rumble_update  out  1  one-cycle pulse when the rumble registers are written
- led_cmd  out  4  XInput LED animation code, 0x0–0xD
- led_update  out  1  one-cycle pulse when led_cmd is written
- pkt_error  out  1  one-cycle pulse when a packet is rejected
- busy  out  1  high while in RECV or CHECK

Behaviour:
- Interface decision: one clock; reset is synchronous and active-low. Clock port is clk, reset port is rstn.
- Reset or usb_rstn=0:
  - state=IDLE; byte count and gap counter cleared.
  - rumble_left, rumble_right, led_cmd = 0; all pulses = 0; busy = 0.
  - An in-flight packet is dropped with no pkt_error.
- State machine (IDLE, RECV, CHECK):
  - IDLE:
    - ep01_valid stores the byte at index 0, sets cnt=1 and goes to RECV.
  - RECV:
    - ep01_valid with cnt<MAX_BYTES stores the byte at index cnt, increments cnt and clears the gap counter.
    - ep01_valid with cnt==MAX_BYTES sets the sticky ovf flag; the byte is discarded and cnt holds.
    - A cycle without valid increments the gap counter. When gap reaches GAP_CYCLES-1, the next state is CHECK.
  - CHECK (one cycle):
    - The packet is evaluated, outputs are registered, and the next state is IDLE.
    - A valid arriving during CHECK is dropped and sets an internal sticky flag. The next packet is still framed from the next valid seen in IDLE.
- Decode rules, with b[n] the captured bytes:
  - Rumble: cnt==8, b0==0x00, b1==0x08, no ovf → rumble_left<=b3, rumble_right<=b4, rumble_update=1. b2, b5–b7 are ignored.
  - LED: cnt==3, b0==0x01, b1==0x03, b2<=0x0D, no ovf → led_cmd<=b2[3:0], led_update=1.
  - Any other packet, including ovf, a length mismatch, or LED code >0x0D → pkt_error=1; held outputs unchanged.
- Latency: with the last byte valid in cycle T, the pulse (update or error) is high in cycle T+GAP_CYCLES+1. Pulses are mutually exclusive and last exactly one cycle.
- busy is 1 from the cycle after the first valid through the CHECK cycle.
- Gap counter width is $clog2(GAP_CYCLES); it never wraps because it is compared before increment.

Optional Feature:
- Macro XOUT_PKT_STATS_EN.
- When defined:
  - Adds outputs good_cnt[15:0] and err_cnt[15:0], both saturating at 0xFFFF.
  - good_cnt increments on each update pulse; err_cnt increments on each pkt_error.
  - Both are cleared by rstn or usb_rstn.
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package xinput_pkg holds:
  - the report type constants XOUT_TYPE_RUMBLE=8'h00 and XOUT_TYPE_LED=8'h01;
  - the lengths XOUT_LEN_RUMBLE=8 and XOUT_LEN_LED=3;
  - XOUT_LED_MAX=4'hD;
  - a state enum typedef.
- One sub-module, xout_pkt_framer: byte capture buffer, count, gap timer, ovf. It emits frame_done with the buffer and count. The parent does the decode and holds the registers.

Test Plan:
- Rumble: bytes 00 08 00 80 40 00 00 00, 40 cycles apart → rumble_left=0x80, rumble_right=0x40, rumble_update high exactly at last+GAP_CYCLES+1, busy low the cycle after.
- LED: 01 03 06 → led_cmd=0x6, led_update pulse; a following 01 03 0E → pkt_error pulse, led_cmd stays 0x6.
- Overflow: 10 bytes starting 00 08 → pkt_error, rumble registers unchanged. A following valid rumble 00 08 00 FF 01 00 00 00 → 0xFF/0x01.
- Back-to-back: two rumble packets separated by a gap of GAP_CYCLES-2 → framed as one 16-byte packet, one pkt_error. A gap of GAP_CYCLES → two rumble_update pulses.
- Mid-packet clear: usb_rstn=0 for 1 cycle after byte 4 of a rumble packet → no pulse, outputs 0, busy=0. The next full LED packet 01 03 02 decodes normally.
- XOUT_PKT_STATS_EN: 3 good packets and 2 bad packets → good_cnt=3, err_cnt=2; after rstn both are 0.
